stack_calc: RTL and testbench
=============================

# stack_calc

Parametrised stack-machine calculator. It fetches a length-prefixed program from an external instruction ROM addressed by `pc` and executes PUSH/arithmetic/stack-manipulation opcodes on an internal LIFO of configurable depth and data width. Results are streamed on `out_data` with a one-cycle `d_valid` strobe. Unlike the previous generation, it detects overflow, underflow and illegal opcodes, halts on them and reports them on `err_code`. It sits between the instruction ROM and the result sink in the lab datapath.

## Interface
- `DW`, 20: data/stack word width, ≥ IMMW
- `DEPTH`, 8: stack entries, ≥ 2
- `IMMW`, 10: immediate width; instruction width is IMMW+3
- `PCW`, 10: program counter width
- `clk`  in  1  single clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `instr`  in  IMMW+3  ROM word at address `pc`, valid combinationally in the same cycle; [IMMW+2:IMMW] opcode, [IMMW-1:0] imm
- `pc`  out  PCW  instruction address (registered)
- `d_valid`  out  1  out_data valid strobe (registered)
- `out_data`  out  DW  result word (registered)
- `err_code`  out  3  000 ok, 001 overflow, 010 underflow, 011 illegal opcode (sticky)
- `fin`  out  1  program finished or halted on error (sticky)
- `level`  out  clog2(DEPTH+1)  current stack occupancy

## Operation
- ROM word 0 = program length L (instr[PCW-1:0]). Instructions occupy addresses 1..L.
- Opcodes:
  - 000 PUSH: push zero-extended imm.
  - 001 ADD, 010 SUB, 011 MUL: b=top, a=next; pop both, push a op b, emit result.
  - 100 OUT: pop top and emit it.
  - 101 DUP: push copy of top.
  - 110, 111: illegal.
- Arithmetic: all modulo 2^DW. SUB wraps (a−b). MUL keeps the low DW bits of the 2·DW product.
- Checks are made in DEC, before any state change:
  - PUSH/DUP with level==DEPTH → 001.
  - ADD/SUB/MUL with level<2 → 010.
  - OUT/DUP with level<1 → 010 (DUP checks underflow first).
  - Illegal opcode → 011.
- On error: stack, level and pc are frozen at the faulting instruction. No d_valid is issued.
- FSM states:
  - LEN: latch L; pc←1; go to DONE if L==0, else DEC.
  - DEC: latch opcode/imm; go to EXE if legal, else ERR.
  - EXE: update stack/level and outputs. If pc==L go to DONE, else pc←pc+1 and go to DEC.
  - DONE: fin=1; hold.
  - ERR: fin=1, err_code held; hold.
- `d_valid`=1 for exactly one cycle after the EXE of ADD/SUB/MUL/OUT. Otherwise 0.
- `out_data` holds its last emitted value when d_valid=0. It is 0 before the first emission.
- Only `rst` leaves DONE/ERR.

## Timing
- Reset (sampled at posedge while rst=1) sets state=LEN, pc=0, d_valid=0, out_data=0, err_code=0, fin=0, level=0. Stack contents are don't-care.
- Reset asserted mid-program aborts immediately. The next program starts from pc=0 on the first cycle after rst falls.
- Cycle 0 is the first cycle after rst deasserts (LEN). Instruction k has DEC in cycle 2k−1 and EXE in cycle 2k.
- fin rises in cycle 2L+1, or cycle 1 when L==0.
- A d_valid strobe from the last instruction coincides with fin rising.
- On an error detected in DEC at cycle 2k−1, err_code and fin rise in cycle 2k. pc stays at k.
- `level` updates at the end of EXE, visible in the next cycle.
- `pc` changes only at the end of LEN or EXE.

## Test plan
1. L=3: PUSH 5, PUSH 3, SUB → d_valid=1 only in cycle 7, out_data=2, fin=1 from cycle 7, err_code=000, level=1, pc=3.
2. L=3: PUSH 3, PUSH 5, SUB (DW=20) → out_data=0xFFFFE. Then, with DW=8: PUSH 200, PUSH 2, MUL → out_data=0x90.
3. DEPTH=8, L=9, nine PUSHes → err_code=001 and fin=1 in cycle 18, pc=9, level=8, d_valid never asserted.
4. L=2: PUSH 1, ADD → err_code=010 in cycle 4, pc=2, level=1. Separately, L=1: OUT on empty stack → 010. Separately, L=1: opcode 111 → 011.
5. L=4: PUSH 7, DUP, ADD, OUT → out_data=14 with d_valid in cycle 7, then 14 again in cycle 9; level=0; fin=1 in cycle 9.
6. rst pulsed during cycle 3 of test 1 → next cycle all outputs at reset values. The rerun reproduces test 1 timing exactly relative to rst release. L=0 → fin=1 in cycle 1, pc=1.

Source files
------------

// File: rtl/stack_calc.sv
// stack_calc: length-prefixed stack-machine calculator that halts on overflow, underflow and illegal opcodes
module stack_calc #(
  parameter int DW    = 20,
  parameter int DEPTH = 8,
  parameter int IMMW  = 10,
  parameter int PCW   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IMMW+2:0]              i_instr,
  output logic [PCW-1:0]               o_pc,
  output logic                         o_d_valid,
  output logic [DW-1:0]                o_out_data,
  output logic [2:0]                   o_err_code,
  output logic                         o_fin,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] OP_PUSH = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3, OP_OUT = 3'd4, OP_DUP = 3'd5;
  typedef enum logic [2:0] {S_LEN, S_DEC, S_EXE, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;
  logic [PCW-1:0] r_pc, r_len;
  logic [2:0] r_op, r_err, w_op, w_chk;
  logic [IMMW-1:0] r_imm;
  logic [LW-1:0] r_level;
  logic [DW-1:0] r_stack [DEPTH];
  logic [DW-1:0] r_out, w_top, w_nxt, w_res;
  logic r_dv;
  logic [AW-1:0] w_ti, w_ni, w_wi;
  assign w_op  = i_instr[IMMW+2:IMMW];
  assign w_ti  = AW'(r_level - LW'(1));
  assign w_ni  = AW'(r_level - LW'(2));
  assign w_wi  = AW'(r_level);
  assign w_top = r_stack[w_ti];
  assign w_nxt = r_stack[w_ni];
  assign w_res = (r_op == OP_ADD) ? w_nxt + w_top : (r_op == OP_SUB) ? w_nxt - w_top : w_nxt * w_top;
  assign w_chk = (w_op[2:1] == 2'b11) ? 3'd3
               : ((((w_op == OP_OUT) || (w_op == OP_DUP)) && (r_level == '0)) ||
                  ((w_op inside {OP_ADD, OP_SUB, OP_MUL}) && (r_level < LW'(2)))) ? 3'd2
               : (((w_op == OP_PUSH) || (w_op == OP_DUP)) && (r_level == LW'(DEPTH))) ? 3'd1
               : 3'd0;
  assign o_pc       = r_pc;
  assign o_d_valid  = r_dv;
  assign o_out_data = r_out;
  assign o_err_code = r_err;
  assign o_fin      = (r_state == S_DONE) || (r_state == S_ERR);
  assign o_level    = r_level;
  // next state: fetch length, then alternate decode/execute until the last instruction or a fault
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN:   w_next = (i_instr[PCW-1:0] == '0) ? S_DONE : S_DEC;
      S_DEC:   w_next = (w_chk != 3'd0) ? S_ERR : S_EXE;
      S_EXE:   w_next = (r_pc == r_len) ? S_DONE : S_DEC;
      default: w_next = r_state;
    endcase
  end
  // state, program counter, decoded instruction, stack and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEN;
      r_pc    <= '0;
      r_len   <= '0;
      r_op    <= '0;
      r_imm   <= '0;
      r_level <= '0;
      r_dv    <= 1'b0;
      r_out   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_next;
      r_dv    <= 1'b0;
      case (r_state)
        S_LEN: begin
          r_len <= i_instr[PCW-1:0];
          r_pc  <= PCW'(1);
        end
        S_DEC: begin
          r_op  <= w_op;
          r_imm <= i_instr[IMMW-1:0];
          r_err <= w_chk;
        end
        S_EXE: begin
          if (r_pc != r_len) r_pc <= r_pc + PCW'(1);
          case (r_op)
            OP_PUSH: begin
              r_stack[w_wi] <= DW'(r_imm);
              r_level       <= r_level + LW'(1);
            end
            OP_DUP: begin
              r_stack[w_wi] <= w_top;
              r_level       <= r_level + LW'(1);
            end
            OP_OUT: begin
              r_level <= r_level - LW'(1);
              r_out   <= w_top;
              r_dv    <= 1'b1;
            end
            default: begin
              r_stack[w_ni] <= w_res;
              r_level       <= r_level - LW'(1);
              r_out         <= w_res;
              r_dv          <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_calc.sv
// tb_stack_calc: random and directed programs checked cycle by cycle against a queue-based model
module tb_stack_calc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] p_op  [0:1023];
  logic [9:0] p_imm [0:1023];
  logic [12:0] instr_a;
  logic [10:0] instr_b;
  logic [9:0] pc_a, pc_b;
  logic dv_a, dv_b, fin_a, fin_b;
  logic [19:0] out_a;
  logic [7:0] out_b;
  logic [2:0] err_a, err_b;
  logic [3:0] lvl_a, lvl_b;
  assign instr_a = {p_op[pc_a], p_imm[pc_a]};
  assign instr_b = {p_op[pc_b], p_imm[pc_b][7:0]};
  stack_calc u_dut (
    .clk(clk), .rst(rst), .i_instr(instr_a), .o_pc(pc_a), .o_d_valid(dv_a),
    .o_out_data(out_a), .o_err_code(err_a), .o_fin(fin_a), .o_level(lvl_a)
  );
  stack_calc #(.DW(8), .IMMW(8)) u_dut8 (
    .clk(clk), .rst(rst), .i_instr(instr_b), .o_pc(pc_b), .o_d_valid(dv_b),
    .o_out_data(out_b), .o_err_code(err_b), .o_fin(fin_b), .o_level(lvl_b)
  );
  int n_tests = 0;
  int n_fail = 0;
  logic        exp_ev  [0:63];
  logic [63:0] exp_val [0:63];
  int lvl_after [0:31];
  int n_ok, fin_cycle, exp_err, exp_pc;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input int k, input int op, input int imm);
    p_op[k]  = 3'(op);
    p_imm[k] = 10'(imm);
  endtask
  task automatic build_model();
    logic [63:0] st[$];
    logic [63:0] a, b, r;
    int len, op, need, e;
    bit grow, emit;
    len = int'(p_imm[0]);
    for (int c = 0; c < 64; c++) begin
      exp_ev[c]  = 1'b0;
      exp_val[c] = '0;
    end
    lvl_after[0] = 0;
    n_ok = 0;
    exp_err = 0;
    exp_pc = (len == 0) ? 1 : len;
    fin_cycle = 2 * len + 1;
    for (int k = 1; k <= len; k++) begin
      op = int'(p_op[k]);
      need = (op >= 1 && op <= 3) ? 2 : (op == 4 || op == 5) ? 1 : 0;
      grow = (op == 0 || op == 5);
      e = (op > 5) ? 3 : (st.size() < need) ? 2 : (grow && st.size() == 8) ? 1 : 0;
      if (e != 0) begin
        exp_err = e;
        exp_pc = k;
        fin_cycle = 2 * k;
        break;
      end
      emit = 1'b0;
      r = '0;
      if (op == 0) st.push_back(64'(p_imm[k]));
      else if (op == 5) st.push_back(st[$]);
      else if (op == 4) begin
        r = st.pop_back();
        emit = 1'b1;
      end else begin
        b = st.pop_back();
        a = st.pop_back();
        r = (op == 1) ? a + b : (op == 2) ? a - b : a * b;
        st.push_back(r);
        emit = 1'b1;
      end
      if (emit) begin
        exp_ev[2*k+1]  = 1'b1;
        exp_val[2*k+1] = r;
      end
      n_ok++;
      lvl_after[n_ok] = st.size();
    end
  endtask
  task automatic start();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic run_check(input string name);
    logic [63:0] last = '0;
    int ep, li;
    for (int c = 0; c <= fin_cycle + 2; c++) begin
      @(negedge clk);
      if (exp_ev[c]) last = exp_val[c];
      ep = (c == 0) ? 0 : (((c + 1) / 2 < exp_pc) ? (c + 1) / 2 : exp_pc);
      li = (c == 0) ? 0 : (((c - 1) / 2 < n_ok) ? (c - 1) / 2 : n_ok);
      chk($sformatf("%s c%0d dv", name, c), 64'(dv_a), 64'(exp_ev[c]));
      chk($sformatf("%s c%0d dv8", name, c), 64'(dv_b), 64'(exp_ev[c]));
      chk($sformatf("%s c%0d out", name, c), 64'(out_a), last & 64'hFFFFF);
      chk($sformatf("%s c%0d out8", name, c), 64'(out_b), last & 64'hFF);
      chk($sformatf("%s c%0d fin", name, c), 64'(fin_a), 64'(c >= fin_cycle));
      chk($sformatf("%s c%0d err", name, c), 64'(err_a), 64'((c >= fin_cycle) ? exp_err : 0));
      chk($sformatf("%s c%0d err8", name, c), 64'(err_b), 64'((c >= fin_cycle) ? exp_err : 0));
      chk($sformatf("%s c%0d pc", name, c), 64'(pc_a), 64'(ep));
      chk($sformatf("%s c%0d lvl", name, c), 64'(lvl_a), 64'(lvl_after[li]));
    end
  endtask
  task automatic run(input string name);
    build_model();
    start();
    run_check(name);
  endtask
  initial begin
    int len, r, op;
    bit heavy;
    for (int i = 0; i < 1024; i++) put(i, 0, 0);
    put(0, 0, 3); put(1, 0, 5); put(2, 0, 3); put(3, 2, 0);
    run("t1");
    chk("t1 out_data", 64'(out_a), 64'd2);
    chk("t1 level", 64'(lvl_a), 64'd1);
    chk("t1 pc", 64'(pc_a), 64'd3);
    put(0, 0, 3); put(1, 0, 3); put(2, 0, 5); put(3, 2, 0);
    run("t2a");
    chk("t2 wrap", 64'(out_a), 64'hFFFFE);
    put(0, 0, 3); put(1, 0, 200); put(2, 0, 2); put(3, 3, 0);
    run("t2b");
    chk("t2 mul8", 64'(out_b), 64'h90);
    chk("t2 mul20", 64'(out_a), 64'd400);
    put(0, 0, 9);
    for (int k = 1; k <= 9; k++) put(k, 0, k);
    run("t3");
    chk("t3 err", 64'(err_a), 64'd1);
    chk("t3 pc", 64'(pc_a), 64'd9);
    chk("t3 level", 64'(lvl_a), 64'd8);
    put(0, 0, 2); put(1, 0, 1); put(2, 1, 0);
    run("t4a");
    chk("t4a err", 64'(err_a), 64'd2);
    put(0, 0, 1); put(1, 4, 0);
    run("t4b");
    chk("t4b err", 64'(err_a), 64'd2);
    put(0, 0, 1); put(1, 7, 0);
    run("t4c");
    chk("t4c err", 64'(err_a), 64'd3);
    put(0, 0, 4); put(1, 0, 7); put(2, 5, 0); put(3, 1, 0); put(4, 4, 0);
    run("t5");
    chk("t5 out", 64'(out_a), 64'd14);
    chk("t5 level", 64'(lvl_a), 64'd0);
    put(0, 0, 3); put(1, 0, 5); put(2, 0, 3); put(3, 2, 0);
    build_model();
    start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6 rst dv", 64'(dv_a), 64'd0);
    chk("t6 rst pc", 64'(pc_a), 64'd0);
    chk("t6 rst fin", 64'(fin_a), 64'd0);
    chk("t6 rst err", 64'(err_a), 64'd0);
    chk("t6 rst lvl", 64'(lvl_a), 64'd0);
    chk("t6 rst out", 64'(out_a), 64'd0);
    rst = 1'b0;
    run_check("t6");
    put(0, 0, 0);
    run("t6z");
    for (int t = 0; t < 40; t++) begin
      heavy = ($urandom_range(0, 3) == 0);
      len = $urandom_range(0, 12);
      put(0, 0, len);
      for (int k = 1; k <= len; k++) begin
        r = $urandom_range(0, 99);
        if (heavy) op = (r < 80) ? 0 : $urandom_range(0, 5);
        else op = (r < 35) ? 0 : (r < 45) ? 1 : (r < 55) ? 2 : (r < 65) ? 3 : (r < 78) ? 4 : (r < 95) ? 5 : $urandom_range(6, 7);
        put(k, op, $urandom_range(0, 255));
      end
      run($sformatf("rnd%0d", t));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
